// File: rtl/fir_cfg_master.sv
// AXI-Lite configuration master for the fir block: writes data_length and taps,
// reads every tap back and checks it, then starts fir and polls until ap_done.
`timescale 1ns/1ps

module fir_cfg_master #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11,
   parameter int POLL_GAP    = 8,
   parameter int TIMEOUT     = 1000000
) (
   input  logic                            axis_clk,
   input  logic                            axis_rst_n,
   input  logic                            cfg_go,
   input  logic [31:0]                     data_len,
   input  logic [Tape_Num*pDATA_WIDTH-1:0] tap_coef,
   output logic                            cfg_busy,
   output logic                            cfg_done,
   output logic [1:0]                      cfg_err,
   output logic [3:0]                      err_idx,
   output logic                            awvalid,
   input  logic                            awready,
   output logic [pADDR_WIDTH-1:0]          awaddr,
   output logic                            wvalid,
   input  logic                            wready,
   output logic [pDATA_WIDTH-1:0]          wdata,
   output logic                            arvalid,
   input  logic                            arready,
   output logic [pADDR_WIDTH-1:0]          araddr,
   input  logic                            rvalid,
   output logic                            rready,
   input  logic [pDATA_WIDTH-1:0]          rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_LEN, S_WR_TAP, S_RD_TAP, S_WR_START, S_POLL, S_DONE, S_ERR
   } state_t;

   localparam logic [3:0]             LAST_TAP  = 4'(Tape_Num - 1);
   localparam logic [31:0]            TMO_LAST  = 32'(TIMEOUT - 1);
   localparam logic [31:0]            GAP       = 32'(POLL_GAP);
   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
   localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16'h0010);
   localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(16'h0080);
   localparam logic [pDATA_WIDTH-1:0] AP_START  = pDATA_WIDTH'(1);
   localparam logic [1:0]             ERR_TAP   = 2'd1;
   localparam logic [1:0]             ERR_TMO   = 2'd2;

   state_t                            state_q, state_d;
   logic                              txn_q, txn_d;
   logic                              awvalid_d, wvalid_d, arvalid_d, rready_d;
   logic [pADDR_WIDTH-1:0]            awaddr_d, araddr_d;
   logic [pDATA_WIDTH-1:0]            wdata_d;
   logic [3:0]                        idx_q, idx_d;
   logic [31:0]                       len_q, len_d;
   logic [Tape_Num*pDATA_WIDTH-1:0]   taps_q, taps_d;
   logic [31:0]                       tmo_q, tmo_d;
   logic [31:0]                       gap_q, gap_d;
   logic                              cfg_done_d;
   logic [1:0]                        cfg_err_d;
   logic [3:0]                        err_idx_d;

   logic [pDATA_WIDTH-1:0]            tap_cur;
   logic [pADDR_WIDTH-1:0]            tap_addr;
   logic                              wr_done, rd_done;

   assign tap_cur  = taps_q[idx_q*pDATA_WIDTH +: pDATA_WIDTH];
   assign tap_addr = ADDR_TAP0 + pADDR_WIDTH'({idx_q, 2'b00});
   // aw and w may finish on different edges; a channel already dropped counts as finished.
   assign wr_done  = txn_q && (!awvalid || awready) && (!wvalid || wready);
   assign rd_done  = txn_q && rready && rvalid;
   assign cfg_busy = !(state_q inside {S_IDLE, S_DONE, S_ERR});

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      txn_d      = txn_q;
      awvalid_d  = awvalid & ~awready;
      wvalid_d   = wvalid & ~wready;
      arvalid_d  = arvalid & ~arready;
      rready_d   = rready & ~rvalid;
      awaddr_d   = awaddr;
      wdata_d    = wdata;
      araddr_d   = araddr;
      idx_d      = idx_q;
      len_d      = len_q;
      taps_d     = taps_q;
      tmo_d      = tmo_q;
      gap_d      = gap_q;
      cfg_done_d = cfg_done;
      cfg_err_d  = cfg_err;
      err_idx_d  = err_idx;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (cfg_go) begin
               len_d      = data_len;
               taps_d     = tap_coef;
               cfg_done_d = 1'b0;
               cfg_err_d  = 2'd0;
               err_idx_d  = 4'd0;
               idx_d      = 4'd0;
               txn_d      = 1'b0;
               state_d    = S_WR_LEN;
            end
         end
         S_WR_LEN: begin
            if (!txn_q) begin
               txn_d     = 1'b1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = ADDR_LEN;
               wdata_d   = pDATA_WIDTH'(len_q);
            end else if (wr_done) begin
               txn_d   = 1'b0;
               idx_d   = 4'd0;
               state_d = S_WR_TAP;
            end
         end
         S_WR_TAP: begin
            if (!txn_q) begin
               txn_d     = 1'b1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = tap_addr;
               wdata_d   = tap_cur;
            end else if (wr_done) begin
               txn_d = 1'b0;
               if (idx_q == LAST_TAP) begin
                  idx_d   = 4'd0;
                  state_d = S_RD_TAP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_RD_TAP: begin
            if (!txn_q) begin
               txn_d     = 1'b1;
               arvalid_d = 1'b1;
               rready_d  = 1'b1;
               araddr_d  = tap_addr;
            end else if (rd_done) begin
               txn_d = 1'b0;
               if (rdata != tap_cur) begin
                  cfg_err_d = ERR_TAP;
                  err_idx_d = idx_q;
                  state_d   = S_ERR;
               end else if (idx_q == LAST_TAP) begin
                  idx_d   = 4'd0;
                  state_d = S_WR_START;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_WR_START: begin
            if (!txn_q) begin
               txn_d     = 1'b1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = ADDR_CTRL;
               wdata_d   = AP_START;
            end else if (wr_done) begin
               txn_d   = 1'b0;
               tmo_d   = 32'd0;
               gap_d   = 32'd0;
               state_d = S_POLL;
            end
         end
         S_POLL: begin
            tmo_d = tmo_q + 32'd1;
            if (rd_done && rdata[1]) begin
               txn_d      = 1'b0;
               cfg_done_d = 1'b1;
               state_d    = S_DONE;
            end else if (tmo_q == TMO_LAST) begin
               // Abandon the outstanding poll; the slave has stopped answering usefully.
               txn_d     = 1'b0;
               arvalid_d = 1'b0;
               rready_d  = 1'b0;
               cfg_err_d = ERR_TMO;
               state_d   = S_ERR;
            end else if (rd_done) begin
               txn_d = 1'b0;
               gap_d = GAP;
            end else if (!txn_q) begin
               if (gap_q != 32'd0) begin
                  gap_d = gap_q - 32'd1;
               end else begin
                  txn_d     = 1'b1;
                  arvalid_d = 1'b1;
                  rready_d  = 1'b1;
                  araddr_d  = ADDR_CTRL;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q  <= S_IDLE;
         txn_q    <= 1'b0;
         awvalid  <= 1'b0;
         wvalid   <= 1'b0;
         arvalid  <= 1'b0;
         rready   <= 1'b0;
         awaddr   <= '0;
         wdata    <= '0;
         araddr   <= '0;
         idx_q    <= 4'd0;
         len_q    <= 32'd0;
         taps_q   <= '0;
         tmo_q    <= 32'd0;
         gap_q    <= 32'd0;
         cfg_done <= 1'b0;
         cfg_err  <= 2'd0;
         err_idx  <= 4'd0;
      end else begin
         state_q  <= state_d;
         txn_q    <= txn_d;
         awvalid  <= awvalid_d;
         wvalid   <= wvalid_d;
         arvalid  <= arvalid_d;
         rready   <= rready_d;
         awaddr   <= awaddr_d;
         wdata    <= wdata_d;
         araddr   <= araddr_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         taps_q   <= taps_d;
         tmo_q    <= tmo_d;
         gap_q    <= gap_d;
         cfg_done <= cfg_done_d;
         cfg_err  <= cfg_err_d;
         err_idx  <= err_idx_d;
      end
   end

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master: an AXI-Lite slave model stands in for fir,
// with switchable awready stall, tap-5 readback corruption and a never-done mode.
`timescale 1ns/1ps

module tb_fir_cfg_master;

   localparam int NT = 11;
   localparam int DW = 32;
   localparam int AW = 12;
   localparam int LOGN = 1024;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_go = 1'b0;
   logic [31:0]       data_len = '0;
   logic [NT*DW-1:0]  tap_coef = '0;
   logic              cfg_busy, cfg_done;
   logic [1:0]        cfg_err;
   logic [3:0]        err_idx;
   logic              awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
   logic [AW-1:0]     awaddr, araddr;
   logic [DW-1:0]     wdata, rdata;

   always #5 clk = ~clk;

   fir_cfg_master #(
      .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT), .POLL_GAP(8), .TIMEOUT(200)
   ) dut (
      .axis_clk(clk), .axis_rst_n(rst_n), .cfg_go(cfg_go), .data_len(data_len),
      .tap_coef(tap_coef), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .err_idx(err_idx), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .arvalid(arvalid),
      .arready(arready), .araddr(araddr), .rvalid(rvalid), .rready(rready), .rdata(rdata)
   );

   // slave model controls
   bit stall_aw = 1'b0, corrupt5 = 1'b0, never_done = 1'b0;

   logic          aw_got, w_got, start_seen = 1'b0;
   logic [AW-1:0] aw_lat;
   logic [DW-1:0] w_lat, reg_len;
   logic [DW-1:0] reg_tap [NT];
   int            stall_cnt, polls = 0;
   int            wr_cnt = 0, rd_cnt = 0, stall_seen = 0, proto_err = 0, cyc = 0;
   logic [AW-1:0] wr_addr_log [LOGN];
   logic [DW-1:0] wr_data_log [LOGN];
   logic [AW-1:0] rd_addr_log [LOGN];

   int total = 0, bad = 0;
   int taps [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready <= 1'b0; wready <= 1'b0; arready <= 1'b0; rvalid <= 1'b0; rdata <= '0;
         aw_got <= 1'b0; w_got <= 1'b0; stall_cnt <= 0;
      end else begin
         if (wvalid && wready) begin
            wready <= 1'b0; w_got <= 1'b1; w_lat <= wdata;
         end else if (wvalid && !w_got) wready <= 1'b1;
         if (awvalid && awready) begin
            awready <= 1'b0; aw_got <= 1'b1; aw_lat <= awaddr;
         end else if (awvalid && !aw_got && (!stall_aw || (w_got && stall_cnt >= 3)))
            awready <= 1'b1;
         if (w_got && !aw_got) stall_cnt <= stall_cnt + 1;
         if (aw_got && w_got) begin
            wr_addr_log[wr_cnt] <= aw_lat;
            wr_data_log[wr_cnt] <= w_lat;
            wr_cnt    <= wr_cnt + 1;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            stall_cnt <= 0;
            if (aw_lat == 12'h010) begin
               reg_len <= w_lat; start_seen <= 1'b0; polls <= 0;
            end else if (aw_lat >= 12'h080 && aw_lat < 12'h080 + 12'(4*NT))
               reg_tap[(aw_lat - 12'h080) >> 2] <= w_lat;
            else if (aw_lat == 12'h000 && w_lat[0])
               start_seen <= 1'b1;
         end
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rd_addr_log[rd_cnt] <= araddr;
            rd_cnt  <= rd_cnt + 1;
            if (araddr == 12'h000) begin
               rdata <= {30'd0, start_seen && !never_done && polls >= 2, 1'b0};
               if (start_seen) polls <= polls + 1;
            end else if (araddr == 12'h010)
               rdata <= reg_len;
            else
               rdata <= reg_tap[(araddr - 12'h080) >> 2] +
                        ((corrupt5 && araddr == 12'h094) ? 32'd1 : 32'd0);
         end else if (arvalid && !rvalid) arready <= 1'b1;
      end
   end

   // protocol monitor: valids held and payload stable until handshake; no read/write overlap
   logic          aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
   logic [AW-1:0] aw_prev, ar_prev;
   logic [DW-1:0] w_prev;
   always @(negedge clk) begin
      if (!rst_n) begin
         aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
      end else begin
         if ((aw_hold && (!awvalid || awaddr !== aw_prev)) ||
             (w_hold && (!wvalid || wdata !== w_prev)) ||
             (ar_hold && (!arvalid || araddr !== ar_prev)) ||
             ((awvalid || wvalid) && (arvalid || rready)))
            proto_err <= proto_err + 1;
         if (awvalid && !wvalid) stall_seen <= stall_seen + 1;
         aw_hold <= awvalid && !awready; aw_prev <= awaddr;
         w_hold  <= wvalid && !wready;   w_prev  <= wdata;
         ar_hold <= arvalid && !arready; ar_prev <= araddr;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [31:0] len);
      @(negedge clk);
      data_len = len;
      for (int i = 0; i < NT; i++) tap_coef[i*DW +: DW] = taps[i];
      cfg_go = 1'b1;
      @(negedge clk);
      cfg_go = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (cfg_busy && n < 3000) begin @(negedge clk); n++; end
      check({tag, "_finish"}, {31'd0, cfg_busy}, 32'd0);
   endtask

   task automatic wait_wr(input int target, input string tag);
      int n = 0;
      while (wr_cnt < target && n < 1000) begin @(negedge clk); n++; end
      check({tag, "_wr_reached"}, {31'd0, wr_cnt >= target}, 32'd1);
   endtask

   task automatic check_clean(input string tag, input int wb, input int rb, input logic [31:0] len);
      check({tag, "_done"}, {31'd0, cfg_done}, 32'd1);
      check({tag, "_err"}, {30'd0, cfg_err}, 32'd0);
      check({tag, "_nwrites"}, 32'(wr_cnt - wb), 32'd13);
      check({tag, "_len_addr"}, 32'(wr_addr_log[wb]), 32'h10);
      check({tag, "_len_data"}, wr_data_log[wb], len);
      for (int n = 0; n < NT; n++) begin
         check({tag, "_tap_waddr"}, 32'(wr_addr_log[wb+1+n]), 32'(12'h080 + 12'(4*n)));
         check({tag, "_tap_wdata"}, wr_data_log[wb+1+n], 32'(taps[n]));
         check({tag, "_tap_raddr"}, 32'(rd_addr_log[rb+n]), 32'(12'h080 + 12'(4*n)));
      end
      check({tag, "_start_addr"}, 32'(wr_addr_log[wb+12]), 32'h0);
      check({tag, "_start_data"}, wr_data_log[wb+12], 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wb, rb, sb, t0, nz;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, cfg_busy}, 32'd0);
      check("rst_done", {31'd0, cfg_done}, 32'd0);
      check("rst_err", {30'd0, cfg_err}, 32'd0);
      check("rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: clean run
      wb = wr_cnt; rb = rd_cnt;
      go(32'd600);
      check("t1_busy_after_go", {31'd0, cfg_busy}, 32'd1);
      wait_idle("t1");
      check_clean("t1", wb, rb, 32'd600);
      check("t1_nreads_taps_first", {31'd0, rd_cnt - rb > NT}, 32'd1);

      // 2: awready stalled after every wready
      stall_aw = 1'b1;
      wb = wr_cnt; rb = rd_cnt; sb = stall_seen;
      go(32'd600);
      wait_idle("t2");
      check_clean("t2", wb, rb, 32'd600);
      check("t2_w_dropped_aw_held", {31'd0, stall_seen - sb >= 13*3}, 32'd1);
      stall_aw = 1'b0;

      // 3: tap 5 reads back 64 instead of 63
      corrupt5 = 1'b1;
      wb = wr_cnt; rb = rd_cnt;
      go(32'd600);
      wait_idle("t3");
      check("t3_err", {30'd0, cfg_err}, 32'd1);
      check("t3_err_idx", {28'd0, err_idx}, 32'd5);
      check("t3_done", {31'd0, cfg_done}, 32'd0);
      check("t3_nwrites", 32'(wr_cnt - wb), 32'd12);
      nz = 0;
      for (int i = wb; i < wr_cnt; i++) if (wr_addr_log[i] == 12'h000) nz++;
      check("t3_no_ap_start", 32'(nz), 32'd0);
      check("t3_nreads", 32'(rd_cnt - rb), 32'd6);
      corrupt5 = 1'b0;

      // 4: ap_done never arrives, TIMEOUT=200
      never_done = 1'b1;
      wb = wr_cnt;
      go(32'd600);
      check("t4_sticky_cleared", {30'd0, cfg_err}, 32'd0);
      wait_wr(wb + 13, "t4");
      t0 = cyc;
      wait_idle("t4");
      check("t4_err", {30'd0, cfg_err}, 32'd2);
      check("t4_done", {31'd0, cfg_done}, 32'd0);
      check("t4_busy", {31'd0, cfg_busy}, 32'd0);
      check("t4_tmo_window", {31'd0, (cyc - t0) >= 190 && (cyc - t0) <= 200}, 32'd1);
      never_done = 1'b0;

      // 5: second cfg_go during WR_TAP is ignored
      wb = wr_cnt; rb = rd_cnt;
      go(32'd600);
      wait_wr(wb + 3, "t5");
      data_len = 32'd77;
      tap_coef = ~tap_coef;
      cfg_go = 1'b1;
      @(negedge clk);
      cfg_go = 1'b0;
      wait_idle("t5");
      check_clean("t5", wb, rb, 32'd600);

      // 6: reset during RD_TAP, then a full clean run
      wb = wr_cnt; rb = rd_cnt;
      go(32'd600);
      t0 = 0;
      while (rd_cnt < rb + 3 && t0 < 1000) begin @(negedge clk); t0++; end
      check("t6_in_rd_tap", {31'd0, rd_cnt >= rb + 3}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_busy", {31'd0, cfg_busy}, 32'd0);
      check("t6_rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
      check("t6_rst_status", {25'd0, cfg_done, cfg_err, err_idx}, 32'd0);
      check("t6_rst_araddr", 32'(araddr), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wb = wr_cnt; rb = rd_cnt;
      go(32'd600);
      wait_idle("t6");
      check_clean("t6", wb, rb, 32'd600);

      check("protocol_violations", 32'(proto_err), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
